// File: rtl/amiga_pll_reconfig_ctrl_if.sv
// Avalon-MM write port from the reconfig controller to the PLL reconfiguration block.
// The controller is the master; the PLL reconfig block is the slave.
interface amiga_pll_reconfig_ctrl_if;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic        write;
    logic        waitrequest;

    modport master (output address, writedata, write, input waitrequest);
    modport slave  (input address, writedata, write, output waitrequest);
endinterface

// File: rtl/amiga_pll_reconfig_ctrl.sv
// Switches the Amiga core PLL between PAL and NTSC through its reconfig port, supervises
// PLL lock and owns the core reset. The per-mode register list comes from an external table.
module amiga_pll_reconfig_ctrl #(
    parameter bit DEFAULT_MODE  = 1'b0,
    parameter int LOCK_STABLE   = 1024,
    parameter int LOCK_TIMEOUT  = 1 << 20,
    parameter int WR_TIMEOUT    = 4096,
    parameter int PLLRST_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      mode,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      cur_mode,
    output logic                      tbl_mode,
    output logic [3:0]                tbl_idx,
    input  logic [5:0]                tbl_addr,
    input  logic [31:0]               tbl_data,
    input  logic                      tbl_last,
    amiga_pll_reconfig_ctrl_if.master mgmt,
    input  logic                      pll_locked,
    output logic                      pll_rst,
    output logic                      core_rst
);

    localparam int TIMER_MAX =
        (LOCK_TIMEOUT > WR_TIMEOUT)
            ? ((LOCK_TIMEOUT > PLLRST_CYCLES) ? LOCK_TIMEOUT : PLLRST_CYCLES)
            : ((WR_TIMEOUT > PLLRST_CYCLES) ? WR_TIMEOUT : PLLRST_CYCLES);
    localparam int TIMER_W  = $clog2(TIMER_MAX + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE + 1);

    localparam logic [TIMER_W-1:0]  WR_LAST     = TIMER_W'(WR_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  PLLRST_LAST = TIMER_W'(PLLRST_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);

    localparam logic [5:0] MODE_ADDR  = 6'h00;
    localparam logic [5:0] START_ADDR = 6'h02;

    typedef enum logic [2:0] {
        IDLE,
        MODE_WR,
        LOAD,
        WRITE,
        START_WR,
        WAIT_LOCK,
        PLL_RESET
    } state_t;

    state_t              state, state_d;
    logic                locked_meta, locked_sync;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [STABLE_W-1:0] stable_cnt, stable_d;
    logic                last_entry, last_d;
    logic                retry, retry_d;
    logic                notify, notify_d;
    logic                loss_seen, loss_d;
    logic                cur_mode_d, tbl_mode_d, done_d, err_d, pll_rst_d, core_rst_d;
    logic [3:0]          tbl_idx_d;
    logic [5:0]          addr_d;
    logic [31:0]         data_d;
    logic                write_d;
    logic                write_done, wr_expired;

    // pll_locked comes from the PLL's own clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;
        end
    end

    assign busy       = (state != IDLE);
    assign write_done = mgmt.write && !mgmt.waitrequest;
    assign wr_expired = (timer == WR_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d    = state;
        timer_d    = '0;
        stable_d   = '0;
        last_d     = last_entry;
        retry_d    = retry;
        notify_d   = notify;
        loss_d     = 1'b0;
        cur_mode_d = cur_mode;
        tbl_mode_d = tbl_mode;
        tbl_idx_d  = tbl_idx;
        addr_d     = mgmt.address;
        data_d     = mgmt.writedata;
        write_d    = mgmt.write;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pll_rst_d  = pll_rst;
        core_rst_d = core_rst;

        case (state)
            IDLE: begin
                // After a failed sequence core_rst is still held; any request restarts the writes.
                if (req && (core_rst || (mode != cur_mode))) begin
                    tbl_mode_d = mode;
                    core_rst_d = 1'b1;
                    retry_d    = 1'b0;
                    notify_d   = 1'b1;
                    addr_d     = MODE_ADDR;
                    data_d     = 32'd0;
                    write_d    = 1'b1;
                    state_d    = MODE_WR;
                end else if (req) begin
                    done_d = 1'b1;
                end else if (!core_rst && !locked_sync) begin
                    if (loss_seen) begin
                        core_rst_d = 1'b1;
                        retry_d    = 1'b0;
                        notify_d   = 1'b0;
                        state_d    = WAIT_LOCK;
                    end else begin
                        loss_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                addr_d  = tbl_addr;
                data_d  = tbl_data;
                last_d  = tbl_last;
                write_d = 1'b1;
                state_d = WRITE;
            end

            MODE_WR, WRITE, START_WR: begin
                if (write_done) begin
                    write_d = 1'b0;
                    if (state == MODE_WR) begin
                        tbl_idx_d = 4'd0;
                        state_d   = LOAD;
                    end else if (state == WRITE) begin
                        if (!last_entry) begin
                            tbl_idx_d = tbl_idx + 4'd1;
                        end
                        if (last_entry || (tbl_idx == 4'hF)) begin
                            addr_d  = START_ADDR;
                            data_d  = 32'd1;
                            write_d = 1'b1;
                            state_d = START_WR;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        cur_mode_d = tbl_mode;
                        state_d    = WAIT_LOCK;
                    end
                end else if (wr_expired) begin
                    write_d   = 1'b0;
                    err_d     = 1'b1;
                    retry_d   = 1'b1;
                    pll_rst_d = 1'b1;
                    state_d   = PLL_RESET;
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end

            WAIT_LOCK: begin
                timer_d = timer + TIMER_W'(1);
                if (locked_sync) begin
                    stable_d = stable_cnt + STABLE_W'(1);
                end
                if (locked_sync && (stable_cnt == STABLE_LAST)) begin
                    done_d     = notify;
                    notify_d   = 1'b1;
                    retry_d    = 1'b0;
                    core_rst_d = 1'b0;
                    state_d    = IDLE;
                end else if (timer == LOCK_LAST) begin
                    timer_d = '0;
                    if (retry) begin
                        err_d   = 1'b1;
                        retry_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        retry_d   = 1'b1;
                        pll_rst_d = 1'b1;
                        state_d   = PLL_RESET;
                    end
                end
            end

            PLL_RESET: begin
                if (timer == PLLRST_LAST) begin
                    pll_rst_d = 1'b0;
                    state_d   = WAIT_LOCK;
                end else begin
                    timer_d = timer + TIMER_W'(1);
                end
            end

            default: begin
                write_d    = 1'b0;
                pll_rst_d  = 1'b0;
                core_rst_d = 1'b1;
                state_d    = WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= WAIT_LOCK;
            timer          <= '0;
            stable_cnt     <= '0;
            last_entry     <= 1'b0;
            retry          <= 1'b0;
            notify         <= 1'b1;
            loss_seen      <= 1'b0;
            cur_mode       <= DEFAULT_MODE;
            tbl_mode       <= DEFAULT_MODE;
            tbl_idx        <= 4'd0;
            mgmt.address   <= 6'd0;
            mgmt.writedata <= 32'd0;
            mgmt.write     <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            pll_rst        <= 1'b0;
            core_rst       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state          <= state_d;
            timer          <= timer_d;
            stable_cnt     <= stable_d;
            last_entry     <= last_d;
            retry          <= retry_d;
            notify         <= notify_d;
            loss_seen      <= loss_d;
            cur_mode       <= cur_mode_d;
            tbl_mode       <= tbl_mode_d;
            tbl_idx        <= tbl_idx_d;
            mgmt.address   <= addr_d;
            mgmt.writedata <= data_d;
            mgmt.write     <= write_d;
            done           <= done_d;
            err            <= err_d;
            pll_rst        <= pll_rst_d;
            core_rst       <= core_rst_d;
        end
    end

endmodule

// File: tb/tb_amiga_pll_reconfig_ctrl.sv
// Directed bench for amiga_pll_reconfig_ctrl: power-up lock, mode switch, lock and write
// timeouts, lock glitches. A 6-entry table and a stalling mgmt slave are modelled here.
module tb_amiga_pll_reconfig_ctrl;

    localparam int LOCK_STABLE   = 16;
    localparam int LOCK_TIMEOUT  = 256;
    localparam int WR_TIMEOUT    = 16;
    localparam int PLLRST_CYCLES = 64;

    logic        clk = 1'b0;
    logic        rst, req, mode, pll_locked;
    logic        busy, done, err, cur_mode, tbl_mode, pll_rst, core_rst;
    logic [3:0]  tbl_idx;
    logic [5:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        tbl_last;

    amiga_pll_reconfig_ctrl_if mgmt ();

    amiga_pll_reconfig_ctrl #(
        .DEFAULT_MODE (1'b0),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .WR_TIMEOUT   (WR_TIMEOUT),
        .PLLRST_CYCLES(PLLRST_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cur_mode  (cur_mode),
        .tbl_mode  (tbl_mode),
        .tbl_idx   (tbl_idx),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .tbl_last  (tbl_last),
        .mgmt      (mgmt),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .core_rst  (core_rst)
    );

    always #5 clk = ~clk;

    // Table: six entries at 0x04.., data tagged 0xA (PAL) or 0xB (NTSC) in the top nibble.
    assign tbl_addr = 6'h04 + {2'b00, tbl_idx};
    assign tbl_data = {(tbl_mode ? 4'hB : 4'hA), 24'h0, tbl_idx};
    assign tbl_last = (tbl_idx == 4'd5);

    int          checks = 0;
    int          errors = 0;
    int          stall_cycles = 3;
    int          stall_cnt = 0;
    int          write_cycles = 0;
    logic [5:0]  log_addr[$];
    logic [31:0] log_data[$];

    // mgmt slave: stalls each write for stall_cycles cycles, then accepts it and logs it.
    initial begin
        mgmt.waitrequest = 1'b1;
        forever begin
            @(negedge clk);
            if (mgmt.write === 1'b1) begin
                write_cycles++;
                if (stall_cnt < stall_cycles) begin
                    mgmt.waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt.waitrequest = 1'b0;
                    stall_cnt = 0;
                    log_addr.push_back(mgmt.address);
                    log_data.push_back(mgmt.writedata);
                end
            end else begin
                mgmt.waitrequest = 1'b1;
                stall_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [5:0]  exp_addr[8];
    logic [31:0] exp_data[8];
    int fall, dones, hi, pulses, fall_t, err_t;
    bit seen_done, seen_err, raised, prev;

    initial begin
        exp_addr = '{6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h02};
        exp_data = '{32'h0, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002,
                     32'hB000_0003, 32'hB000_0004, 32'hB000_0005, 32'h1};

        rst = 1'b1; req = 1'b0; mode = 1'b0; pll_locked = 1'b0;
        tick(3);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cur_mode", cur_mode, 0);
        check("rst_write", mgmt.write, 0);
        check("rst_addr", mgmt.address, 0);
        check("rst_data", mgmt.writedata, 0);
        check("rst_pll_rst", pll_rst, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_tbl_idx", tbl_idx, 0);

        // Power-up: lock 10 cycles after reset release.
        rst = 1'b0;
        tick(10);
        pll_locked = 1'b1;
        fall = 0; dones = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) dones++;
            if (!core_rst && fall == 0) fall = k;
        end
        check("pwrup_core_rst_fall", fall, 2 + LOCK_STABLE);
        check("pwrup_done_count", dones, 1);
        check("pwrup_busy", busy, 0);

        // Request for the mode already programmed.
        write_cycles = 0;
        req = 1'b1; mode = 1'b0;
        tick();
        req = 1'b0;
        check("same_done", done, 1);
        check("same_busy", busy, 0);
        check("same_core_rst", core_rst, 0);
        tick();
        check("same_done_clr", done, 0);
        tick(5);
        check("same_no_write", write_cycles, 0);
        check("same_core_rst_hold", core_rst, 0);

        // PAL -> NTSC, lock drops during reconfig and returns after the start write.
        log_addr.delete(); log_data.delete();
        req = 1'b1; mode = 1'b1;
        tick();
        req = 1'b0; pll_locked = 1'b0;
        check("sw_busy", busy, 1);
        check("sw_core_rst", core_rst, 1);
        check("sw_tbl_mode", tbl_mode, 1);
        check("sw_first_write", mgmt.write, 1);
        check("sw_first_addr", mgmt.address, 0);
        tick(4);
        req = 1'b1; mode = 1'b0;
        tick();
        req = 1'b0;
        seen_done = 0; seen_err = 0; raised = 0;
        for (int k = 0; k < 400 && !seen_done; k++) begin
            if (log_addr.size() == 8 && !raised) begin
                pll_locked = 1'b1;
                raised = 1;
            end
            tick();
            if (done) seen_done = 1;
            if (err) seen_err = 1;
        end
        check("sw_done", seen_done, 1);
        check("sw_no_err", seen_err, 0);
        check("sw_nwrites", log_addr.size(), 8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check($sformatf("sw_addr%0d", i), log_addr[i], exp_addr[i]);
            check($sformatf("sw_data%0d", i), log_data[i], exp_data[i]);
        end
        check("sw_cur_mode", cur_mode, 1);
        check("sw_core_rst", core_rst, 0);
        check("sw_idle", busy, 0);

        // NTSC -> PAL with lock never returning.
        log_addr.delete(); log_data.delete();
        req = 1'b1; mode = 1'b0;
        tick();
        req = 1'b0; pll_locked = 1'b0;
        hi = 0; pulses = 0; fall_t = 0; err_t = 0; prev = 0;
        for (int k = 1; k <= 1500 && err_t == 0; k++) begin
            tick();
            if (pll_rst) hi++;
            if (pll_rst && !prev) pulses++;
            if (!pll_rst && prev) fall_t = k;
            prev = pll_rst;
            if (err) err_t = k;
        end
        check("lto_err_seen", err_t != 0, 1);
        check("lto_pulses", pulses, 1);
        check("lto_width", hi, PLLRST_CYCLES);
        check("lto_err_delay", err_t - fall_t, LOCK_TIMEOUT);
        check("lto_core_rst", core_rst, 1);
        check("lto_idle", busy, 0);
        check("lto_cur_mode", cur_mode, 0);
        check("lto_nwrites", log_addr.size(), 8);
        tick();
        check("lto_err_pulse", err, 0);
        tick(20);
        check("lto_core_rst_hold", core_rst, 1);
        check("lto_stays_idle", busy, 0);

        // Restart after failure.
        pll_locked = 1'b1;
        tick(3);
        req = 1'b1; mode = 1'b0;
        tick();
        req = 1'b0;
        check("rs_busy", busy, 1);
        check("rs_write", mgmt.write, 1);
        seen_done = 0;
        for (int k = 0; k < 400 && !seen_done; k++) begin
            tick();
            if (done) seen_done = 1;
        end
        check("rs_done", seen_done, 1);
        check("rs_core_rst", core_rst, 0);
        check("rs_cur_mode", cur_mode, 0);

        // waitrequest stuck high.
        stall_cycles = 1000;
        req = 1'b1; mode = 1'b1;
        tick();
        req = 1'b0;
        hi = 0;
        while (mgmt.write && hi < 100) begin
            hi++;
            tick();
        end
        check("wto_write_len", hi, WR_TIMEOUT);
        check("wto_err", err, 1);
        check("wto_pll_rst", pll_rst, 1);
        check("wto_core_rst", core_rst, 1);
        check("wto_busy", busy, 1);
        tick();
        check("wto_err_pulse", err, 0);
        stall_cycles = 3;
        write_cycles = 0;
        seen_done = 0;
        for (int k = 0; k < 300 && !seen_done; k++) begin
            tick();
            if (done) seen_done = 1;
        end
        check("wto_relock_done", seen_done, 1);
        check("wto_no_rewrite", write_cycles, 0);
        check("wto_cur_mode", cur_mode, 0);
        check("wto_core_rst_rel", core_rst, 0);

        // One-cycle lock glitch is ignored.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick(8);
        check("gl1_core_rst", core_rst, 0);
        check("gl1_busy", busy, 0);

        // Three-cycle loss: silent recovery, requests ignored meanwhile.
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(2);
        check("gl3_core_rst", core_rst, 1);
        check("gl3_busy", busy, 1);
        write_cycles = 0;
        req = 1'b1; mode = 1'b1;
        tick();
        req = 1'b0;
        dones = 0;
        for (int k = 0; k < 100 && core_rst; k++) begin
            tick();
            if (done) dones++;
        end
        tick(3);
        if (done) dones++;
        check("gl3_recovered", core_rst, 0);
        check("gl3_no_done", dones, 0);
        check("gl3_idle", busy, 0);
        check("gl3_req_ignored_mode", cur_mode, 0);
        check("gl3_req_ignored_wr", write_cycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
